// File: rtl/mem_access_unit_pkg.sv
// Shared constants and state encoding for the memory access unit.
// Optional wait timeout is enabled by defining MAU_TIMEOUT_EN.
package mem_access_unit_pkg;

   localparam int unsigned MAU_WORD_SIZE      = 16;
   localparam int unsigned MAU_TIMEOUT_CYCLES = 64;

   // Sequencer states (2-bit encoding shared with the control unit)
   typedef enum logic [1:0] {
      MAU_IDLE    = 2'b00,
      MAU_RD_WAIT = 2'b01,
      MAU_WR_WAIT = 2'b10,
      MAU_DONE    = 2'b11
   } mau_state_e;

endpackage : mem_access_unit_pkg

// File: rtl/mem_access_unit_wait_counter.sv
// Saturating wait-cycle counter with synchronous clear/enable and a
// registered terminal-count flag that is high while the count sits at LIMIT-1.
// Only instantiated when MAU_TIMEOUT_EN is defined.
module mem_wait_counter #(
   parameter int unsigned LIMIT = 64
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear_i,
   input  logic en_i,
   output logic term_o
);

   localparam int unsigned CNT_W = (LIMIT > 2) ? $clog2(LIMIT) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LIMIT - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             term_q;

   // Next count: clear wins, otherwise count up and hold at the maximum
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Count and terminal flag registers
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt_q  <= '0;
         term_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         term_q <= (cnt_d == CNT_MAX);
      end
   end

   assign term_o = term_q;

endmodule : mem_wait_counter

// File: rtl/mem_access_unit.sv
// Multi-cycle memory port sequencer: turns control's level MemRead/MemWrite
// requests into one handshaked bus transaction each, loads IR/MDR and pulses done.
// Define MAU_TIMEOUT_EN to abort waits after TIMEOUT_CYCLES and flag mem_err.
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int unsigned WORD_SIZE      = MAU_WORD_SIZE,
   parameter int unsigned TIMEOUT_CYCLES = MAU_TIMEOUT_CYCLES
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 req_read,
   input  logic                 req_write,
   input  logic                 req_is_data,
   input  logic [WORD_SIZE-1:0] pc,
   input  logic [WORD_SIZE-1:0] alu_out,
   input  logic [WORD_SIZE-1:0] wdata,
   output logic                 readM,
   output logic                 writeM,
   output logic [WORD_SIZE-1:0] address,
   output logic [WORD_SIZE-1:0] mem_wdata,
   input  logic [WORD_SIZE-1:0] mem_rdata,
   input  logic                 inputReady,
   input  logic                 ackOutput,
   output logic [WORD_SIZE-1:0] ir,
   output logic [WORD_SIZE-1:0] mdr,
   output logic                 done,
   output logic                 busy,
   output logic                 mem_err
);

   mau_state_e state_q, state_d;

   logic [WORD_SIZE-1:0] addr_q, addr_d;
   logic [WORD_SIZE-1:0] wdat_q, wdat_d;
   logic                 is_data_q, is_data_d;
   logic [WORD_SIZE-1:0] ir_q, ir_d;
   logic [WORD_SIZE-1:0] mdr_q, mdr_d;
   logic                 err_q, err_d;
   logic                 read_q, write_q, done_q, busy_q;
   logic                 wait_tmo;

`ifdef MAU_TIMEOUT_EN
   logic cnt_clear, cnt_en;

   assign cnt_clear = (state_q == MAU_IDLE);
   assign cnt_en    = (state_q == MAU_RD_WAIT) || (state_q == MAU_WR_WAIT);

   mem_wait_counter #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_wait_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .clear_i (cnt_clear),
      .en_i    (cnt_en),
      .term_o  (wait_tmo)
   );
`else
   assign wait_tmo = 1'b0;
`endif

   // Next-state, transaction latch and capture logic
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdat_d    = wdat_q;
      is_data_d = is_data_q;
      ir_d      = ir_q;
      mdr_d     = mdr_q;
      err_d     = err_q;
      case (state_q)
         MAU_IDLE: begin
            if (req_write) begin
               addr_d    = alu_out;
               wdat_d    = wdata;
               is_data_d = 1'b1;
               state_d   = MAU_WR_WAIT;
            end else if (req_read) begin
               addr_d    = req_is_data ? alu_out : pc;
               is_data_d = req_is_data;
               state_d   = MAU_RD_WAIT;
            end
         end
         MAU_RD_WAIT: begin
            if (inputReady) begin
               if (is_data_q) begin
                  mdr_d = mem_rdata;
               end else begin
                  ir_d = mem_rdata;
               end
               state_d = MAU_DONE;
            end else if (wait_tmo) begin
               err_d   = 1'b1;
               state_d = MAU_DONE;
            end
         end
         MAU_WR_WAIT: begin
            if (ackOutput) begin
               state_d = MAU_DONE;
            end else if (wait_tmo) begin
               err_d   = 1'b1;
               state_d = MAU_DONE;
            end
         end
         MAU_DONE: begin
            if (!req_read && !req_write) begin
               state_d = MAU_IDLE;
            end
         end
         default: state_d = MAU_IDLE;
      endcase
   end

   // State, datapath and registered output decode
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= MAU_IDLE;
         addr_q    <= '0;
         wdat_q    <= '0;
         is_data_q <= 1'b0;
         ir_q      <= '0;
         mdr_q     <= '0;
         err_q     <= 1'b0;
         read_q    <= 1'b0;
         write_q   <= 1'b0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdat_q    <= wdat_d;
         is_data_q <= is_data_d;
         ir_q      <= ir_d;
         mdr_q     <= mdr_d;
         err_q     <= err_d;
         read_q    <= (state_d == MAU_RD_WAIT);
         write_q   <= (state_d == MAU_WR_WAIT);
         done_q    <= (state_d == MAU_DONE) && (state_q != MAU_DONE);
         busy_q    <= (state_d != MAU_IDLE);
      end
   end

   assign readM     = read_q;
   assign writeM    = write_q;
   assign address   = addr_q;
   assign mem_wdata = wdat_q;
   assign ir        = ir_q;
   assign mdr       = mdr_q;
   assign done      = done_q;
   assign busy      = busy_q;
`ifdef MAU_TIMEOUT_EN
   assign mem_err   = err_q;
`else
   assign mem_err   = 1'b0;
`endif

endmodule : mem_access_unit

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: fetch, load, store, held request,
// simultaneous requests, ignored handshakes and (with MAU_TIMEOUT_EN) timeout.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        req_read, req_write, req_is_data;
   logic [15:0] pc, alu_out, wdata;
   logic        readM, writeM;
   logic [15:0] address, mem_wdata, mem_rdata;
   logic        inputReady, ackOutput;
   logic [15:0] ir, mdr;
   logic        done, busy, mem_err;

   int total = 0;
   int bad   = 0;
   int hits;

   always #5 clk = ~clk;

   mem_access_unit #(
      .WORD_SIZE      (16),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .req_read    (req_read),
      .req_write   (req_write),
      .req_is_data (req_is_data),
      .pc          (pc),
      .alu_out     (alu_out),
      .wdata       (wdata),
      .readM       (readM),
      .writeM      (writeM),
      .address     (address),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .inputReady  (inputReady),
      .ackOutput   (ackOutput),
      .ir          (ir),
      .mdr         (mdr),
      .done        (done),
      .busy        (busy),
      .mem_err     (mem_err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      reset_n = 1'b0; req_read = 1'b0; req_write = 1'b0; req_is_data = 1'b0;
      pc = '0; alu_out = '0; wdata = '0; mem_rdata = '0;
      inputReady = 1'b0; ackOutput = 1'b0;
      tick(); tick();
      chk("rst_readM", 16'(readM), 16'h0);
      chk("rst_writeM", 16'(writeM), 16'h0);
      chk("rst_done", 16'(done), 16'h0);
      chk("rst_busy", 16'(busy), 16'h0);
      chk("rst_err", 16'(mem_err), 16'h0);
      chk("rst_addr", address, 16'h0000);
      chk("rst_ir", ir, 16'h0000);
      chk("rst_mdr", mdr, 16'h0000);
      reset_n = 1'b1;
      tick();

      // Fetch: response two cycles after acceptance
      req_read = 1'b1; req_is_data = 1'b0; pc = 16'h0010;
      tick();
      chk("fetch_readM", 16'(readM), 16'h1);
      chk("fetch_addr", address, 16'h0010);
      chk("fetch_busy", 16'(busy), 16'h1);
      pc = 16'h7777;
      tick();
      chk("fetch_wait_readM", 16'(readM), 16'h1);
      chk("fetch_wait_addr", address, 16'h0010);
      chk("fetch_wait_done", 16'(done), 16'h0);
      inputReady = 1'b1; mem_rdata = 16'hF01C;
      tick();
      inputReady = 1'b0;
      chk("fetch_ir", ir, 16'hF01C);
      chk("fetch_done", 16'(done), 16'h1);
      chk("fetch_readM_low", 16'(readM), 16'h0);
      chk("fetch_mdr", mdr, 16'h0000);
      req_read = 1'b0;
      tick();
      chk("fetch_idle_busy", 16'(busy), 16'h0);
      chk("fetch_idle_done", 16'(done), 16'h0);

      // Load: minimum latency, inputs changed during wait are ignored
      req_read = 1'b1; req_is_data = 1'b1; alu_out = 16'h00C0; pc = 16'h0010;
      tick();
      chk("load_addr", address, 16'h00C0);
      chk("load_readM", 16'(readM), 16'h1);
      inputReady = 1'b1; mem_rdata = 16'h1234; alu_out = 16'hFFFF; req_is_data = 1'b0;
      tick();
      inputReady = 1'b0;
      chk("load_mdr", mdr, 16'h1234);
      chk("load_ir", ir, 16'hF01C);
      chk("load_done", 16'(done), 16'h1);
      req_read = 1'b0;
      tick();

      // Store: ack after three strobe cycles
      req_write = 1'b1; alu_out = 16'h00C4; wdata = 16'hBEEF;
      hits = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (writeM && address == 16'h00C4 && mem_wdata == 16'hBEEF) hits++;
         alu_out = 16'h0000; wdata = 16'h0000;
      end
      chk("store_held_cycles", 16'(hits), 16'd3);
      ackOutput = 1'b1;
      tick();
      ackOutput = 1'b0;
      chk("store_done", 16'(done), 16'h1);
      chk("store_writeM_low", 16'(writeM), 16'h0);
      tick();
      chk("store_done_once", 16'(done), 16'h0);
      chk("store_hold_busy", 16'(busy), 16'h1);
      req_write = 1'b0;
      tick();
      chk("store_idle_busy", 16'(busy), 16'h0);

      // Held request: one transaction only, handshake in DONE ignored
      req_read = 1'b1; req_is_data = 1'b0; pc = 16'h0020;
      tick();
      inputReady = 1'b1; mem_rdata = 16'hABCD;
      tick();
      chk("held_ir", ir, 16'hABCD);
      chk("held_done", 16'(done), 16'h1);
      mem_rdata = 16'h5555;
      hits = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (readM || done || !busy) hits++;
      end
      inputReady = 1'b0;
      chk("held_no_retrigger", 16'(hits), 16'd0);
      chk("held_ir_kept", ir, 16'hABCD);
      req_read = 1'b0;
      tick();
      chk("held_release_busy", 16'(busy), 16'h0);

      // Handshake in IDLE ignored
      inputReady = 1'b1; ackOutput = 1'b1; mem_rdata = 16'h9999;
      tick();
      inputReady = 1'b0; ackOutput = 1'b0;
      chk("idle_hs_busy", 16'(busy), 16'h0);
      chk("idle_hs_ir", ir, 16'hABCD);
      chk("idle_hs_mdr", mdr, 16'h1234);

      // Both requests: write wins
      req_read = 1'b1; req_write = 1'b1; alu_out = 16'h0100; wdata = 16'h1111; pc = 16'h0200;
      tick();
      chk("both_writeM", 16'(writeM), 16'h1);
      chk("both_readM", 16'(readM), 16'h0);
      chk("both_addr", address, 16'h0100);
      ackOutput = 1'b1;
      tick();
      ackOutput = 1'b0;
      chk("both_done", 16'(done), 16'h1);
      chk("both_readM_after", 16'(readM), 16'h0);
      req_read = 1'b0; req_write = 1'b0;
      tick();
      chk("both_idle", 16'(busy), 16'h0);

      // Reset mid-transaction aborts
      req_read = 1'b1; req_is_data = 1'b1; alu_out = 16'h0040;
      tick();
      reset_n = 1'b0; inputReady = 1'b1; mem_rdata = 16'h4242;
      tick();
      chk("midrst_readM", 16'(readM), 16'h0);
      chk("midrst_mdr", mdr, 16'h0000);
      reset_n = 1'b1; inputReady = 1'b0; req_read = 1'b0;
      tick();

`ifdef MAU_TIMEOUT_EN
      // Timeout: strobe held TIMEOUT_CYCLES then aborted
      req_read = 1'b1; req_is_data = 1'b0; pc = 16'h0300;
      tick();
      hits = 0;
      if (readM) hits++;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (readM) hits++;
         if (done) break;
      end
      chk("tmo_read_cycles", 16'(hits), 16'd8);
      chk("tmo_done", 16'(done), 16'h1);
      chk("tmo_err", 16'(mem_err), 16'h1);
      chk("tmo_ir", ir, 16'h0000);
      req_read = 1'b0;
      tick();
      tick();
      chk("tmo_err_sticky", 16'(mem_err), 16'h1);
      reset_n = 1'b0;
      tick();
      chk("tmo_err_cleared", 16'(mem_err), 16'h0);
      reset_n = 1'b1;
      tick();
`else
      // Without timeout support the wait is indefinite and mem_err stays low
      req_read = 1'b1; req_is_data = 1'b0; pc = 16'h0300;
      for (int i = 0; i < 80; i++) tick();
      chk("notmo_still_waiting", 16'(readM), 16'h1);
      chk("notmo_err", 16'(mem_err), 16'h0);
      inputReady = 1'b1; mem_rdata = 16'h0BAD;
      tick();
      inputReady = 1'b0; req_read = 1'b0;
      chk("notmo_ir", ir, 16'h0BAD);
      tick();
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_mem_access_unit
